// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
//  Shared types and constants for the GPU command sequencer:
//   - opcode_t     : 3-bit command opcode carried in cmd_data[26:24]
//   - seq_state_t  : sequencer FSM states
//   - point_t      : screen point {x[8:0], y[7:0]}
//   - GPU_XMAX/YMAX: default coordinate limits (320x240 drawing buffer)
//   - STAT_*       : bit positions inside the 32-bit status word
// -----------------------------------------------------------------------------
package gpu_pkg;

    typedef enum logic [2:0] {
        OP_CLEAR      = 3'd0,
        OP_SET_START  = 3'd1,
        OP_SET_END    = 3'd2,
        OP_SET_COLOR  = 3'd3,
        OP_MOVE_START = 3'd4,
        OP_MOVE_END   = 3'd5,
        OP_DRAW       = 3'd6,
        OP_FLIP       = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_EXEC       = 2'd1,
        ST_DRAW_WAIT  = 2'd2,
        ST_CLEAR_WAIT = 2'd3
    } seq_state_t;

    localparam int GPU_XMAX = 319;
    localparam int GPU_YMAX = 239;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
    } point_t;

    // Status word layout: {16'b0, err, busy, full, empty, back_sel, 3'b0, count[7:0]}
    localparam int STAT_ERR   = 15;
    localparam int STAT_BUSY  = 14;
    localparam int STAT_FULL  = 13;
    localparam int STAT_EMPTY = 12;
    localparam int STAT_BACK  = 11;

    // Point payload: x in [16:8], y in [7:0]; bits [23:17] carry nothing.
    function automatic point_t payload_point(input logic [16:0] payload);
        point_t p;
        p.x = payload[16:8];
        p.y = payload[7:0];
        return p;
    endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// gpu_cmd_fifo
//  Synchronous FIFO holding command words for the sequencer. DEPTH must be a
//  power of two >= 2 so the read/write pointers wrap naturally.
//  Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_push, i_data    write request / word (ignored while full)
//   i_pop             read request (ignored while empty)
//   o_data            head word (valid while !o_empty)
//   o_full, o_empty   occupancy flags derived from the registered count
//   o_count           number of stored words (0..DEPTH)
// -----------------------------------------------------------------------------
module gpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop in the full cycle frees the slot only from the next cycle on,
    // because the flags are derived from the registered count.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == {(AW+1){1'b0}});
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage array write
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gpu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// gpu_cmd_sequencer
//  Queues 32-bit command words from the APB slave, keeps the pen state
//  (start/end point, colour, back-buffer select) and launches one drawing
//  engine job at a time with a start/done handshake.
//  Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cmd_valid/i_cmd_data       command word offer; o_cmd_ready = queue not full
//   o_draw_start / i_draw_done   line engine handshake (one-cycle pulses)
//   o_clear_start / i_clear_done clear engine handshake (one-cycle pulses)
//   o_x0,o_y0,o_x1,o_y1          line endpoints
//   o_color                      24-bit RGB pen colour
//   o_back_sel                   buffer being drawn (front = ~back_sel)
//   o_status                     {16'b0, err, busy, full, empty, back_sel, 3'b0, count}
//  Command word: {[31:27] must be 0, [26:24] opcode, [23:0] payload}.
// -----------------------------------------------------------------------------
module gpu_cmd_sequencer
    import gpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int XMAX       = GPU_XMAX,
    parameter int YMAX       = GPU_YMAX
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    input  logic [31:0] i_cmd_data,
    output logic        o_cmd_ready,
    output logic        o_draw_start,
    input  logic        i_draw_done,
    output logic        o_clear_start,
    input  logic        i_clear_done,
    output logic [8:0]  o_x0,
    output logic [7:0]  o_y0,
    output logic [8:0]  o_x1,
    output logic [7:0]  o_y1,
    output logic [23:0] o_color,
    output logic        o_back_sel,
    output logic [31:0] o_status
);

    localparam int AW = $clog2(FIFO_DEPTH);
    // Limits widened to the 10-bit sum width used by the saturating adders.
    localparam logic [9:0] XLIM = 10'(XMAX);
    localparam logic [9:0] YLIM = 10'(YMAX);

    // Queue interface
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_head;
    logic        w_full;
    logic        w_empty;
    logic [AW:0] w_count;

    // Sequencer state and pen registers
    seq_state_t  r_state;
    logic [31:0] r_cmd;
    logic [8:0]  r_x0;
    logic [7:0]  r_y0;
    logic [8:0]  r_x1;
    logic [7:0]  r_y1;
    logic [23:0] r_color;
    logic        r_back_sel;
    logic        r_err;
    logic        r_draw_start;
    logic        r_clear_start;

    // Decoded fields of the command under execution
    opcode_t     w_op;
    point_t      w_pt;
    logic        w_set_oor;
    logic [31:0] w_status;

    // Clamp a point coordinate to the legal range.
    function automatic logic [8:0] clamp_x(input logic [8:0] x);
        if ({1'b0, x} > XLIM) begin
            return XLIM[8:0];
        end else begin
            return x;
        end
    endfunction

    function automatic logic [7:0] clamp_y(input logic [7:0] y);
        if ({2'b00, y} > YLIM) begin
            return YLIM[7:0];
        end else begin
            return y;
        end
    endfunction

    // Add with both operands zero-extended to 10 bits, so the sum can never
    // wrap before it is compared against the limit.
    function automatic logic [8:0] sat_add_x(input logic [8:0] a, input logic [8:0] b);
        logic [9:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > XLIM) begin
            return XLIM[8:0];
        end else begin
            return s[8:0];
        end
    endfunction

    function automatic logic [7:0] sat_add_y(input logic [7:0] a, input logic [7:0] b);
        logic [9:0] s;
        s = {2'b00, a} + {2'b00, b};
        if (s > YLIM) begin
            return YLIM[7:0];
        end else begin
            return s[7:0];
        end
    endfunction

    // The FSM only pops from IDLE, so a job never overlaps the next command.
    assign w_push = i_cmd_valid && !w_full;
    assign w_pop  = (r_state == ST_IDLE) && !w_empty;

    gpu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (i_cmd_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_op      = opcode_t'(r_cmd[26:24]);
    assign w_pt      = payload_point(r_cmd[16:0]);
    assign w_set_oor = ({1'b0, w_pt.x} > XLIM) || ({2'b00, w_pt.y} > YLIM);

    // Sequencer FSM: pop, execute one command, wait for engine completion
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_cmd         <= 32'd0;
            r_x0          <= 9'd0;
            r_y0          <= 8'd0;
            r_x1          <= 9'd0;
            r_y1          <= 8'd0;
            r_color       <= 24'd0;
            r_back_sel    <= 1'b0;
            r_err         <= 1'b0;
            r_draw_start  <= 1'b0;
            r_clear_start <= 1'b0;
        end else begin
            // Start strobes are single-cycle unless re-armed below.
            r_draw_start  <= 1'b0;
            r_clear_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_cmd   <= w_head;
                        r_state <= ST_EXEC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_IDLE;
                    if (r_cmd[31:27] != 5'd0) begin
                        // Malformed word: dropped, error is sticky until reset.
                        r_err <= 1'b1;
                    end else begin
                        case (w_op)
                            OP_CLEAR: begin
                                r_clear_start <= 1'b1;
                                r_state       <= ST_CLEAR_WAIT;
                            end
                            OP_SET_START: begin
                                r_x0 <= clamp_x(w_pt.x);
                                r_y0 <= clamp_y(w_pt.y);
                                if (w_set_oor) begin
                                    r_err <= 1'b1;
                                end
                            end
                            OP_SET_END: begin
                                r_x1 <= clamp_x(w_pt.x);
                                r_y1 <= clamp_y(w_pt.y);
                                if (w_set_oor) begin
                                    r_err <= 1'b1;
                                end
                            end
                            OP_SET_COLOR: begin
                                r_color <= r_cmd[23:0];
                            end
                            OP_MOVE_START: begin
                                r_x0 <= sat_add_x(r_x0, w_pt.x);
                                r_y0 <= sat_add_y(r_y0, w_pt.y);
                            end
                            OP_MOVE_END: begin
                                r_x1 <= sat_add_x(r_x1, w_pt.x);
                                r_y1 <= sat_add_y(r_y1, w_pt.y);
                            end
                            OP_DRAW: begin
                                r_draw_start <= 1'b1;
                                r_state      <= ST_DRAW_WAIT;
                            end
                            OP_FLIP: begin
                                r_back_sel <= ~r_back_sel;
                            end
                            default: begin
                                r_state <= ST_IDLE;
                            end
                        endcase
                    end
                end
                // Pen state is left untouched while an engine runs; only the
                // matching done pulse releases the wait.
                ST_DRAW_WAIT: begin
                    if (i_draw_done) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_DRAW_WAIT;
                    end
                end
                ST_CLEAR_WAIT: begin
                    if (i_clear_done) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_CLEAR_WAIT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status word assembled from registered state only
    always_comb begin
        w_status             = 32'd0;
        w_status[STAT_ERR]   = r_err;
        w_status[STAT_BUSY]  = (r_state != ST_IDLE) || !w_empty;
        w_status[STAT_FULL]  = w_full;
        w_status[STAT_EMPTY] = w_empty;
        w_status[STAT_BACK]  = r_back_sel;
        w_status[7:0]        = 8'(w_count);
    end

    assign o_cmd_ready   = !w_full;
    assign o_draw_start  = r_draw_start;
    assign o_clear_start = r_clear_start;
    assign o_x0          = r_x0;
    assign o_y0          = r_y0;
    assign o_x1          = r_x1;
    assign o_y1          = r_y1;
    assign o_color       = r_color;
    assign o_back_sel    = r_back_sel;
    assign o_status      = w_status;

endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gpu_cmd_sequencer
//  Self-checking bench. A transaction-level model updates the expected pen
//  state when a word is accepted; DUT state is compared whenever the
//  sequencer has gone idle. A monitor process plays both drawing engines.
// -----------------------------------------------------------------------------
module tb_gpu_cmd_sequencer;

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic        cmd_valid   = 1'b0;
    logic [31:0] cmd_data    = 32'd0;
    logic        cmd_ready;
    logic        draw_start;
    logic        draw_done   = 1'b0;
    logic        clear_start;
    logic        clear_done  = 1'b0;
    logic [8:0]  x0, x1;
    logic [7:0]  y0, y1;
    logic [23:0] color;
    logic        back_sel;
    logic [31:0] status;

    gpu_cmd_sequencer #(.FIFO_DEPTH(4), .XMAX(319), .YMAX(239)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cmd_valid   (cmd_valid),
        .i_cmd_data    (cmd_data),
        .o_cmd_ready   (cmd_ready),
        .o_draw_start  (draw_start),
        .i_draw_done   (draw_done),
        .o_clear_start (clear_start),
        .i_clear_done  (clear_done),
        .o_x0          (x0),
        .o_y0          (y0),
        .o_x1          (x1),
        .o_y1          (y1),
        .o_color       (color),
        .o_back_sel    (back_sel),
        .o_status      (status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    int m_x0 = 0, m_y0 = 0, m_x1 = 0, m_y1 = 0, m_color = 0, m_back = 0, m_err = 0;
    int m_draws = 0, m_clears = 0;
    logic [57:0] exp_draw [256];

    function automatic void model_reset();
        m_x0 = 0; m_y0 = 0; m_x1 = 0; m_y1 = 0;
        m_color = 0; m_back = 0; m_err = 0;
    endfunction

    function automatic void model_apply(input logic [31:0] w);
        int op, x, y;
        op = int'(w[26:24]);
        x  = int'(w[16:8]);
        y  = int'(w[7:0]);
        if (w[31:27] != 5'd0) begin
            m_err = 1;
            return;
        end
        case (op)
            0: m_clears++;
            1, 2: begin
                if (x > 319) begin x = 319; m_err = 1; end
                if (y > 239) begin y = 239; m_err = 1; end
                if (op == 1) begin m_x0 = x; m_y0 = y; end
                else         begin m_x1 = x; m_y1 = y; end
            end
            3: m_color = int'(w[23:0]);
            4: begin
                m_x0 = (m_x0 + x > 319) ? 319 : m_x0 + x;
                m_y0 = (m_y0 + y > 239) ? 239 : m_y0 + y;
            end
            5: begin
                m_x1 = (m_x1 + x > 319) ? 319 : m_x1 + x;
                m_y1 = (m_y1 + y > 239) ? 239 : m_y1 + y;
            end
            6: begin
                exp_draw[m_draws[7:0]] = {m_x0[8:0], m_y0[7:0], m_x1[8:0], m_y1[7:0], m_color[23:0]};
                m_draws++;
            end
            default: m_back = 1 - m_back;
        endcase
    endfunction

    // Expected observable state once the sequencer is idle with an empty queue.
    function automatic logic [90:0] model_vec();
        logic [31:0] st;
        st     = 32'h0000_1000;
        st[15] = m_err[0];
        st[11] = m_back[0];
        return {m_x0[8:0], m_y0[7:0], m_x1[8:0], m_y1[7:0], m_color[23:0], m_back[0], st};
    endfunction

    function automatic logic [31:0] mk(input int op, input int payload);
        return {5'd0, op[2:0], payload[23:0]};
    endfunction

    function automatic logic [31:0] mkpt(input int op, input int x, input int y);
        return mk(op, (x << 8) | y);
    endfunction

    logic [90:0] dut_vec;
    assign dut_vec = {x0, y0, x1, y1, color, back_sel, status};

    // ---------------- engine model / monitor ----------------
    int          draw_cnt   = 0;
    int          clear_cnt  = 0;
    logic [57:0] got_draw [256];
    int          d_pend     = -1;
    int          c_pend     = -1;
    int          done_delay = 3;
    bit          auto_done  = 1'b1;
    int          man_req    = 0;
    int          man_seen   = 0;

    // Engine responder: counts start pulses, captures draw arguments, returns done
    always @(posedge clk) begin
        #1;
        draw_done  = 1'b0;
        clear_done = 1'b0;
        if (draw_start === 1'b1) begin
            got_draw[draw_cnt[7:0]] = {x0, y0, x1, y1, color};
            draw_cnt++;
            d_pend = auto_done ? done_delay : -1;
        end else if (d_pend > 0) begin
            d_pend--;
        end
        if (d_pend == 0) begin
            draw_done = 1'b1;
            d_pend    = -1;
        end
        if (clear_start === 1'b1) begin
            clear_cnt++;
            c_pend = auto_done ? done_delay : -1;
        end else if (c_pend > 0) begin
            c_pend--;
        end
        if (c_pend == 0) begin
            clear_done = 1'b1;
            c_pend     = -1;
        end
        if (man_seen != man_req) begin
            draw_done = 1'b1;
            man_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic push(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = w;
        while (cmd_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL push_timeout ready=%b required 1", cmd_ready);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            model_apply(w);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (status[14] !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL idle_timeout busy=%b required 0", status[14]);
        end
    endtask

    task automatic wait_draw(input int target);
        int n;
        n = 0;
        while (draw_cnt < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (draw_cnt < target) begin
            errors++;
            $display("FAIL draw_start_timeout got %0d pulses required %0d", draw_cnt, target);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b required 1", cmd_ready);
        end
        checks++;
        if ({draw_start, clear_start} !== 2'b00) begin
            errors++; $display("FAIL reset_starts got %b required 00", {draw_start, clear_start});
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++; $display("FAIL reset_state got %h required %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_basic_draw();
        int d0;
        d0 = draw_cnt;
        done_delay = 4;
        push(mkpt(1, 0, 0));
        push(mkpt(2, 319, 239));
        push(mk(3, 24'h00FF00));
        push(mk(6, 0));
        wait_idle();
        checks++;
        if (draw_cnt !== d0 + 1) begin
            errors++; $display("FAIL basic_draw_count got %0d required %0d", draw_cnt, d0 + 1);
        end
        checks++;
        if (got_draw[d0[7:0]] !== {9'd0, 8'd0, 9'd319, 8'd239, 24'h00FF00}) begin
            errors++; $display("FAIL basic_draw_args got %h required %h", got_draw[d0[7:0]],
                               {9'd0, 8'd0, 9'd319, 8'd239, 24'h00FF00});
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++; $display("FAIL basic_state got %h required %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_latency();
        logic [23:0] old_c, new_c;
        for (int i = 0; i < 3; i++) begin
            old_c = color;
            new_c = 24'($urandom);
            push(mk(3, int'(new_c)));
            @(posedge clk); #1;
            checks++;
            if (color !== old_c) begin
                errors++; $display("FAIL latency_early got %h required %h", color, old_c);
            end
            @(posedge clk); #1;
            checks++;
            if (color !== new_c) begin
                errors++; $display("FAIL latency_visible got %h required %h", color, new_c);
            end
        end
    endtask

    task automatic test_back_to_back();
        int d0, bad;
        auto_done = 1'b0;
        d0 = draw_cnt;
        push(mkpt(1, $urandom_range(0, 319), $urandom_range(0, 239)));
        push(mk(6, 0));
        wait_draw(d0 + 1);
        push(mk(3, int'($urandom_range(0, 24'hFFFFFF))));
        push(mk(6, 0));
        push(mkpt(5, 1, 1));
        push(mk(7, 0));
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL full_ready got %b required 0", cmd_ready);
        end
        checks++;
        if ({status[14], status[13], status[7:0]} !== {1'b1, 1'b1, 8'd4}) begin
            errors++; $display("FAIL full_status got %h required busy,full,count=4", status);
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (draw_cnt != d0 + 1 || cmd_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL held_off got %0d bad cycles (draws %0d) required 0", bad, draw_cnt);
        end
        auto_done = 1'b1;
        man_req++;
        push(mk(3, int'($urandom_range(0, 24'hFFFFFF))));
        wait_idle();
        checks++;
        if (draw_cnt !== m_draws) begin
            errors++; $display("FAIL b2b_draw_count got %0d required %0d", draw_cnt, m_draws);
        end
        for (int k = d0; k < d0 + 2; k++) begin
            checks++;
            if (got_draw[k[7:0]] !== exp_draw[k[7:0]]) begin
                errors++; $display("FAIL b2b_draw_args[%0d] got %h required %h", k,
                                   got_draw[k[7:0]], exp_draw[k[7:0]]);
            end
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++; $display("FAIL b2b_state got %h required %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_saturate();
        push(mkpt(1, 318, 0));
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            push(mkpt(4, 1, 0));
            wait_idle();
            checks++;
            if ({x0, status[15]} !== {9'd319, 1'b0}) begin
                errors++; $display("FAIL saturate_x0[%0d] got x0=%0d err=%b required 319 err=0",
                                   i, x0, status[15]);
            end
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++; $display("FAIL saturate_state got %h required %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_flip();
        if (m_back != 0) begin
            push(mk(7, 0));
            wait_idle();
        end
        for (int i = 0; i < 2; i++) begin
            push(mk(7, 0));
            wait_idle();
            checks++;
            if ({back_sel, status[11]} !== {m_back[0], m_back[0]}) begin
                errors++; $display("FAIL flip[%0d] got back_sel=%b status11=%b required %0d",
                                   i, back_sel, status[11], m_back);
            end
        end
    endtask

    task automatic test_bad_word();
        int c0;
        c0 = clear_cnt;
        push(32'h0800_0000);
        wait_idle();
        checks++;
        if (clear_cnt !== c0) begin
            errors++; $display("FAIL bad_word_dropped got %0d clears required %0d", clear_cnt, c0);
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++; $display("FAIL bad_word_state got %h required %h", dut_vec, model_vec());
        end
        push(mk(3, 24'h123456));
        wait_idle();
        checks++;
        if (status[15] !== 1'b1) begin
            errors++; $display("FAIL err_sticky got %b required 1", status[15]);
        end
        push(mk(0, 0));
        wait_idle();
        checks++;
        if (clear_cnt !== c0 + 1) begin
            errors++; $display("FAIL clear_pulse got %0d clears required %0d", clear_cnt, c0 + 1);
        end
    endtask

    task automatic test_reset_in_wait();
        int d0;
        auto_done = 1'b0;
        d0 = draw_cnt;
        push(mk(6, 0));
        wait_draw(d0 + 1);
        do_reset();
        man_req++;
        repeat (10) @(negedge clk);
        checks++;
        if (draw_cnt !== d0 + 1) begin
            errors++; $display("FAIL rst_wait_no_draw got %0d pulses required %0d", draw_cnt, d0 + 1);
        end
        checks++;
        if ({cmd_ready, draw_start, clear_start, status} !== {3'b100, 32'h0000_1000}) begin
            errors++; $display("FAIL rst_wait_outputs got ready=%b status=%h required 1/00001000",
                               cmd_ready, status);
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++; $display("FAIL rst_wait_state got %h required %h", dut_vec, model_vec());
        end
        auto_done = 1'b1;
    endtask

    task automatic test_random();
        int d0, c0, op;
        logic [31:0] w;
        d0 = draw_cnt;
        c0 = clear_cnt;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 7);
            w  = mk(op, int'($urandom_range(0, 24'hFFFFFF)));
            if ($urandom_range(0, 15) == 0) w[31:27] = 5'($urandom_range(1, 31));
            done_delay = $urandom_range(1, 5);
            push(w);
            if (i % 10 == 9) begin
                wait_idle();
                checks++;
                if (dut_vec !== model_vec()) begin
                    errors++; $display("FAIL random_state[%0d] got %h required %h", i, dut_vec, model_vec());
                end
            end
        end
        checks++;
        if (draw_cnt !== m_draws || clear_cnt - c0 < 0) begin
            errors++; $display("FAIL random_draw_count got %0d required %0d", draw_cnt, m_draws);
        end
        for (int k = d0; k < m_draws && k < 256; k++) begin
            checks++;
            if (got_draw[k[7:0]] !== exp_draw[k[7:0]]) begin
                errors++; $display("FAIL random_draw_args[%0d] got %h required %h", k,
                                   got_draw[k[7:0]], exp_draw[k[7:0]]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_draw();
        test_latency();
        test_back_to_back();
        test_saturate();
        test_flip();
        test_bad_word();
        test_reset_in_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d required completion", checks);
        $fatal(1, "watchdog");
    end

endmodule
